gpio_cfg_serializer: RTL and testbench

//  Management-side transmitter for the per-pad GPIO configuration chains in front of mprj_io.
//  On a start pulse it snapshots a parallel per-pad config image and shifts it out on two serial

---
 rtl/gpio_cfg_serializer_pkg.sv | 35 +++
 rtl/gpio_cfg_serializer_shift_chain.sv | 38 +++
 rtl/gpio_cfg_serializer.sv | 173 +++++++++++++++++
 tb/tb_gpio_cfg_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_serializer_pkg.sv
// Shared types and constants for the GPIO pad configuration serializer.
// Holds the per-pad config field map and the reset-default pad word.
package gpio_cfg_serializer_pkg;

    localparam int CFG_BITS_DEF = 13;

    // Bit offsets of the fields inside one pad config word
    localparam int CFG_MGMT_EN     = 0;
    localparam int CFG_OEB         = 1;
    localparam int CFG_HOLD_OVR    = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW_SEL    = 8;
    localparam int CFG_VTRIP_SEL   = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_W        = 3;

    localparam logic [CFG_BITS_DEF-1:0] CFG_RESET_DEF = 13'h1803;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } xfer_state_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpio_cfg_serializer_shift_chain.sv
// Parallel-load PISO for one pad config chain, MSB first, zero-filled.
// The image is right-aligned in LEN bits so shorter chains lead with zeros.
module gpio_cfg_shift_chain #(
    parameter int NPADS    = 1,
    parameter int CFG_BITS = 13,
    parameter int LEN      = 13
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [NPADS*CFG_BITS-1:0] pads_i,
    output logic                      sdo_o
);

    logic [LEN-1:0] sr_q;
    logic [LEN-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = LEN'(pads_i);
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sdo_o = sr_q[LEN-1];

endmodule

// File: rtl/gpio_cfg_serializer.sv
// Serial transmitter for the two mprj_io pad configuration chains.
// Snapshots the config image, shifts both chains in lockstep, then strobes load.
module gpio_cfg_serializer
    import gpio_cfg_serializer_pkg::*;
#(
    parameter int AREA1PADS  = 19,
    parameter int TOTAL_PADS = 38,
    parameter int CFG_BITS   = CFG_BITS_DEF,
    parameter int CLK_DIV    = 4
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           xfer_start,
    input  logic [TOTAL_PADS*CFG_BITS-1:0] cfg_data,
    output logic                           busy,
    output logic                           done,
    output logic                           serial_clock,
    output logic                           serial_load,
    output logic                           serial_resetn,
    output logic                           serial_data_1,
    output logic                           serial_data_2
);

    localparam int NP1 = AREA1PADS;
    localparam int NP2 = TOTAL_PADS - AREA1PADS;
    localparam int L1  = NP1 * CFG_BITS;
    localparam int L2  = NP2 * CFG_BITS;
    localparam int N   = imax(L1, L2);
    localparam int PW  = $clog2(CLK_DIV) + 1;
    localparam int BW  = $clog2(N + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    xfer_state_e   state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sclk_q, sclk_d;
    logic load_q, load_d;
    logic rstn_q;

    logic load_en;
    logic shift_en;
    logic [L2-1:0] pads2;

    // Chain 2 runs from pad AREA1PADS outward, so its pad order is flipped
    always_comb begin
        pads2 = '0;
        for (int p = 0; p < NP2; p++) begin
            pads2[p*CFG_BITS +: CFG_BITS] =
                cfg_data[(TOTAL_PADS-1-p)*CFG_BITS +: CFG_BITS];
        end
    end

    gpio_cfg_shift_chain #(
        .NPADS    (NP1),
        .CFG_BITS (CFG_BITS),
        .LEN      (N)
    ) u_chain1 (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (load_en),
        .shift_i (shift_en),
        .pads_i  (cfg_data[L1-1:0]),
        .sdo_o   (serial_data_1)
    );

    gpio_cfg_shift_chain #(
        .NPADS    (NP2),
        .CFG_BITS (CFG_BITS),
        .LEN      (N)
    ) u_chain2 (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (load_en),
        .shift_i (shift_en),
        .pads_i  (pads2),
        .sdo_o   (serial_data_2)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer_start) begin
                    state_d = ST_SHIFT_LO;
                    phase_d = '0;
                    bit_d   = '0;
                    load_en = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_q == PH_LAST) begin
                    // Data only advances as the clock falls
                    phase_d  = '0;
                    shift_en = 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_LOAD: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_DONE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) ||
                 (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
        sclk_d = (state_d == ST_SHIFT_HI);
        load_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
            rstn_q  <= 1'b1;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign serial_clock  = sclk_q;
    assign serial_load   = load_q;
    assign serial_resetn = rstn_q;

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Directed bench for gpio_cfg_serializer: two instances (D=2 unequal, D=1 equal).
// Captures serial chains at rising serial_clock and rebuilds pad images.
module tb_gpio_cfg_serializer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] cfg;

    logic a_busy, a_done, a_sclk, a_load, a_rstn, a_d1, a_d2;
    logic b_busy, b_done, b_sclk, b_load, b_rstn, b_d1, b_d2;

    int n_assert = 0;
    int n_fail   = 0;

    int r_done_k, r_done_cnt, r_ld_first, r_ld_cnt, r_ld_nz;
    int r_busy_first, r_busy_after, r_unstable, r_nbits;
    logic [31:0] r_sh1, r_sh2, r_lat1, r_lat2;
    logic [5:0]  r_rs;
    logic [19:0] rc;

    gpio_cfg_serializer #(
        .AREA1PADS  (2),
        .TOTAL_PADS (5),
        .CFG_BITS   (4),
        .CLK_DIV    (2)
    ) dut_a (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .xfer_start    (start),
        .cfg_data      (cfg),
        .busy          (a_busy),
        .done          (a_done),
        .serial_clock  (a_sclk),
        .serial_load   (a_load),
        .serial_resetn (a_rstn),
        .serial_data_1 (a_d1),
        .serial_data_2 (a_d2)
    );

    gpio_cfg_serializer #(
        .AREA1PADS  (2),
        .TOTAL_PADS (4),
        .CFG_BITS   (4),
        .CLK_DIV    (1)
    ) dut_b (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .xfer_start    (start),
        .cfg_data      (cfg[15:0]),
        .busy          (b_busy),
        .done          (b_done),
        .serial_clock  (b_sclk),
        .serial_load   (b_load),
        .serial_resetn (b_rstn),
        .serial_data_1 (b_d1),
        .serial_data_2 (b_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] rx_img(input logic [31:0] l1,
                                           input logic [31:0] l2,
                                           input int np2);
        logic [19:0] r;
        r = '0;
        r[7:0] = l1[7:0];
        for (int j = 0; j < np2; j++) begin
            r[8+j*4 +: 4] = l2[(np2-1-j)*4 +: 4];
        end
        return r;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input bit sel, input logic [19:0] c0,
                        input logic [19:0] c1, input int cfg_at,
                        input int s1, input int s2, input int rst_at,
                        input int budget);
        logic ob, od, os, ol, orn, o1, o2;
        logic pb_s, pb_l, p1, p2;
        r_done_k = 0; r_done_cnt = 0; r_ld_first = 0; r_ld_cnt = 0;
        r_ld_nz = 0; r_busy_first = 0; r_busy_after = 0;
        r_unstable = 0; r_nbits = 0;
        r_sh1 = '0; r_sh2 = '0; r_lat1 = '0; r_lat2 = '0; r_rs = '1;
        @(negedge clk);
        cfg = c0;
        start = 1'b1;
        @(posedge clk);
        pb_s = 1'b0; pb_l = 1'b0; p1 = 1'b0; p2 = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            ob  = sel ? b_busy : a_busy;
            od  = sel ? b_done : a_done;
            os  = sel ? b_sclk : a_sclk;
            ol  = sel ? b_load : a_load;
            orn = sel ? b_rstn : a_rstn;
            o1  = sel ? b_d1   : a_d1;
            o2  = sel ? b_d2   : a_d2;
            if (ob && r_busy_first == 0) r_busy_first = k;
            if (od) begin
                r_done_cnt++;
                if (r_done_k == 0) r_done_k = k;
            end
            if (r_done_k != 0 && ob) r_busy_after++;
            if (os && (o1 != p1 || o2 != p2)) r_unstable++;
            if (os && !pb_s) begin
                r_sh1 = {r_sh1[30:0], o1};
                r_sh2 = {r_sh2[30:0], o2};
                r_nbits++;
            end
            if (ol) begin
                r_ld_cnt++;
                if (r_ld_first == 0) r_ld_first = k;
                if (o1 || o2) r_ld_nz++;
                if (!pb_l) begin
                    r_lat1 = r_sh1;
                    r_lat2 = r_sh2;
                end
            end
            if (k == rst_at + 1) r_rs = {ob, od, os, orn, o1, o2};
            pb_s = os; pb_l = ol; p1 = o1; p2 = o2;
            start = (k == s1) || (k == s2);
            rst   = (k == rst_at);
            if (k == cfg_at) cfg = c1;
            if (r_done_k != 0 && k >= r_done_k + 4) break;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cfg   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_outs", {a_busy, a_done, a_sclk, a_load, a_rstn, a_d1, a_d2}, 0);
        chk("rst_b_outs", {b_busy, b_done, b_sclk, b_load, b_rstn, b_d1, b_d2}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstn_after_release", a_rstn, 1);
        chk("busy_after_release", a_busy, 0);

        // Directed transfer
        xfer(0, 20'hEDCBA, 20'hEDCBA, 0, 0, 0, 0, 100);
        chk("t2_done_k", r_done_k, 51);
        chk("t2_done_cnt", r_done_cnt, 1);
        chk("t2_busy_first", r_busy_first, 1);
        chk("t2_busy_at_after_done", r_busy_after, 0);
        chk("t2_nbits", r_nbits, 12);
        chk("t2_chain1", r_sh1[11:0], 12'h0BA);
        chk("t2_chain2", r_sh2[11:0], 12'hCDE);
        chk("t2_load_first", r_ld_first, 49);
        chk("t2_load_cnt", r_ld_cnt, 2);
        chk("t2_load_data_zero", r_ld_nz, 0);
        chk("t2_sclk_hi_stable", r_unstable, 0);
        chk("t2_rx_img", rx_img(r_lat1, r_lat2, 3), 20'hEDCBA);
        settle(2);

        // Random images through the receiver model
        for (int i = 0; i < 200; i++) begin
            rc = 20'($urandom);
            xfer(0, rc, rc, 0, 0, 0, 0, 100);
            chk("t3_done_k", r_done_k, 51);
            chk("t3_rx_img", rx_img(r_lat1, r_lat2, 3), rc);
            settle(2);
        end

        // Ignored starts and late cfg changes
        xfer(0, 20'hEDCBA, 20'h12345, 3, 5, 51, 0, 100);
        chk("t4_chain1", r_sh1[11:0], 12'h0BA);
        chk("t4_chain2", r_sh2[11:0], 12'hCDE);
        chk("t4_done_k", r_done_k, 51);
        chk("t4_done_cnt", r_done_cnt, 1);
        chk("t4_no_restart", r_busy_after, 0);
        chk("t4_rx_img", rx_img(r_lat1, r_lat2, 3), 20'hEDCBA);
        settle(40);

        // Reset in the middle of a transfer
        xfer(0, 20'h13579, 20'h13579, 0, 0, 0, 19, 70);
        chk("t5_reset_snapshot", r_rs, 6'b000000);
        chk("t5_no_done", r_done_cnt, 0);
        settle(3);
        chk("t5_rstn_back", a_rstn, 1);
        xfer(0, 20'h13579, 20'h13579, 0, 0, 0, 0, 100);
        chk("t5_fresh_done_k", r_done_k, 51);
        chk("t5_fresh_rx_img", rx_img(r_lat1, r_lat2, 3), 20'h13579);
        settle(40);

        // Equal chains with CLK_DIV=1
        xfer(1, 20'h05A3C, 20'h05A3C, 0, 0, 0, 0, 60);
        chk("t6_done_k", r_done_k, 18);
        chk("t6_nbits", r_nbits, 8);
        chk("t6_chain1", r_sh1[7:0], 8'h3C);
        chk("t6_chain2", r_sh2[7:0], 8'hA5);
        chk("t6_load_first", r_ld_first, 17);
        chk("t6_load_cnt", r_ld_cnt, 1);
        chk("t6_sclk_hi_stable", r_unstable, 0);
        chk("t6_rx_img", rx_img(r_lat1, r_lat2, 2), 20'h05A3C);
        settle(40);
        for (int i = 0; i < 5; i++) begin
            rc = {4'h0, 16'($urandom)};
            xfer(1, rc, rc, 0, 0, 0, 0, 60);
            chk("t6r_done_k", r_done_k, 18);
            chk("t6r_sclk_hi_stable", r_unstable, 0);
            chk("t6r_rx_img", rx_img(r_lat1, r_lat2, 2), rc);
            settle(40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
